// File: rtl/synapse_accumulator_if.sv
// synapse_accumulator_if: spike, weight-load, control and read-port bundle for synapse_accumulator
//   spike : spk_valid, spk_tag (to accumulator), spk_ready (FIFO dequeue, from accumulator)
//   load  : ld_en, ld_src, ld_dst, ld_weight (to accumulator), ld_ack (from accumulator)
//   ctrl  : clr_req, swap_req, decay_shift (to accumulator); sat, busy, state_out (from accumulator)
//   read  : rd_en, rd_tag (to accumulator); rd_data, rd_valid (from accumulator)
interface synapse_accumulator_if #(
  parameter int TAG_BITS = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH = 17,
  parameter int SHIFT_W = 3
);
  logic spk_valid;
  logic [TAG_BITS-1:0] spk_tag;
  logic spk_ready;
  logic ld_en;
  logic [TAG_BITS-1:0] ld_src;
  logic [TAG_BITS-1:0] ld_dst;
  logic [WEIGHT_WIDTH-1:0] ld_weight;
  logic ld_ack;
  logic clr_req;
  logic swap_req;
  logic [SHIFT_W-1:0] decay_shift;
  logic rd_en;
  logic [TAG_BITS-1:0] rd_tag;
  logic signed [ACC_WIDTH-1:0] rd_data;
  logic rd_valid;
  logic sat;
  logic busy;
  logic [2:0] state_out;
  modport master (
    output spk_valid, spk_tag, ld_en, ld_src, ld_dst, ld_weight, clr_req, swap_req, decay_shift, rd_en, rd_tag,
    input spk_ready, ld_ack, rd_data, rd_valid, sat, busy, state_out
  );
  modport slave (
    input spk_valid, spk_tag, ld_en, ld_src, ld_dst, ld_weight, clr_req, swap_req, decay_shift, rd_en, rd_tag,
    output spk_ready, ld_ack, rd_data, rd_valid, sat, busy, state_out
  );
endinterface

// File: rtl/synapse_accumulator.sv
// synapse_accumulator: event-driven saturating synaptic current accumulator with double-buffered currents
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : synapse_accumulator_if.slave (spike handshake, weight load, clear/swap control, current read)
module synapse_accumulator #(
  parameter int TAG_BITS = 4,
  parameter int NUM_NEURONS = 2**TAG_BITS,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH = 17,
  parameter int SHIFT_W = 3
) (
  input logic clk,
  input logic reset,
  synapse_accumulator_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FETCH = 3'b001,
    ACCUM = 3'b011,
    SWAP  = 3'b010,
    CLEAR = 3'b100
  } state_t;
  state_t state;
  logic swap_pending;
  logic accept;
  logic [TAG_BITS-1:0] tag_q;
  logic [TAG_BITS-1:0] cnt;
  logic signed [WEIGHT_WIDTH-1:0] w [NUM_NEURONS][NUM_NEURONS];
  logic signed [WEIGHT_WIDTH-1:0] row [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] cur [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] nxt [NUM_NEURONS];
  logic signed [ACC_WIDTH:0] sum [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] acc [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] clamp;
  // gated by reset so the FIFO is never dequeued while the block is held in reset
  assign bus.spk_ready = reset && (state == ACCUM || (state == IDLE && !bus.clr_req && !bus.ld_en));
  assign accept = bus.spk_valid && bus.spk_ready;
  assign bus.busy = state != IDLE || swap_pending;
  assign bus.state_out = state;
  // one guard bit detects overflow; clamp toward the sign of the true sum
  always_comb begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      sum[k] = {nxt[k][ACC_WIDTH-1], nxt[k]} + {{(ACC_WIDTH+1-WEIGHT_WIDTH){row[k][WEIGHT_WIDTH-1]}}, row[k]};
      clamp[k] = sum[k][ACC_WIDTH] != sum[k][ACC_WIDTH-1];
      acc[k] = clamp[k] ? {sum[k][ACC_WIDTH], {(ACC_WIDTH-1){~sum[k][ACC_WIDTH]}}} : sum[k][ACC_WIDTH-1:0];
    end
  end
  // weight storage and row fetch are deliberately not reset
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && !bus.clr_req && bus.ld_en)
      w[bus.ld_src][bus.ld_dst] <= bus.ld_weight;
    if (state == CLEAR)
      for (int k = 0; k < NUM_NEURONS; k++) w[cnt][k] <= '0;
    if (state == FETCH)
      row <= w[tag_q];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      swap_pending <= 1'b0;
      bus.sat <= 1'b0;
      bus.ld_ack <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      tag_q <= '0;
      cnt <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        cur[k] <= '0;
        nxt[k] <= '0;
      end
    end else begin
      bus.ld_ack <= 1'b0;
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= cur[bus.rd_tag];
      swap_pending <= swap_pending | bus.swap_req;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= CLEAR;
            cnt <= '0;
            swap_pending <= bus.swap_req;
            for (int k = 0; k < NUM_NEURONS; k++) begin
              cur[k] <= '0;
              nxt[k] <= '0;
            end
          end else if (bus.ld_en) begin
            bus.ld_ack <= 1'b1;
          end else if (bus.spk_valid) begin
            tag_q <= bus.spk_tag;
            state <= FETCH;
          end else if (swap_pending) begin
            state <= SWAP;
          end
        end
        FETCH: state <= ACCUM;
        ACCUM: begin
          for (int k = 0; k < NUM_NEURONS; k++) nxt[k] <= acc[k];
          bus.sat <= bus.sat | (|clamp);
          if (accept) tag_q <= bus.spk_tag;
          state <= accept ? FETCH : swap_pending ? SWAP : IDLE;
        end
        SWAP: begin
          for (int k = 0; k < NUM_NEURONS; k++) begin
            cur[k] <= nxt[k];
            nxt[k] <= nxt[k] >>> bus.decay_shift;
          end
          // a request landing on the swap cycle itself belongs to the next timestep
          swap_pending <= bus.swap_req;
          bus.sat <= 1'b0;
          state <= IDLE;
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == TAG_BITS'(NUM_NEURONS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_synapse_accumulator.sv
// tb_synapse_accumulator: self-checking bench for synapse_accumulator
module tb_synapse_accumulator;
  localparam int TB = 4;
  localparam int N = 16;
  localparam int WW = 8;
  localparam int AW = 17;
  localparam int SW = 3;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));
  typedef struct {int tag; int nspk; int shift; int exp5; int exp6;} step_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int swaps = 0;
  int wm [N][N];
  int mcur [N];
  int mnxt [N];
  bit msat = 1'b0;
  int fifo [$];
  int acc_cyc [$];
  bit pend_take = 1'b0;
  step_t steps [7];
  synapse_accumulator_if #(.TAG_BITS(TB), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .SHIFT_W(SW)) bus ();
  synapse_accumulator #(.TAG_BITS(TB), .NUM_NEURONS(N), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .SHIFT_W(SW))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.state_out == 3'b010) swaps <= swaps + 1;
  function automatic void m_spike(int t);
    for (int k = 0; k < N; k++) begin
      int v;
      v = mnxt[k] + wm[t][k];
      if (v > AMAX) begin v = AMAX; msat = 1'b1; end
      else if (v < AMIN) begin v = AMIN; msat = 1'b1; end
      mnxt[k] = v;
    end
  endfunction
  function automatic void m_swap(int sh);
    for (int k = 0; k < N; k++) begin
      mcur[k] = mnxt[k];
      mnxt[k] = mnxt[k] >>> sh;
    end
    msat = 1'b0;
  endfunction
  // show-ahead spike FIFO; a tag is popped (and modelled) once the edge that consumed it has passed
  initial begin
    bus.spk_valid = 1'b0;
    bus.spk_tag = '0;
    forever begin
      @(negedge clk);
      if (pend_take && reset) begin
        m_spike(fifo.pop_front());
        acc_cyc.push_back(cyc);
      end
      bus.spk_valid = fifo.size() > 0;
      bus.spk_tag = fifo.size() > 0 ? TB'(fifo[0]) : '0;
      #1 pend_take = bus.spk_valid && bus.spk_ready;
    end
  end
  task automatic check(string nm, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic wait_idle(string nm);
    int n = 0;
    while ((bus.busy || fifo.size() != 0 || bus.spk_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle_timeout"}, n < 5000, 1);
  endtask
  task automatic wait_state(int s, string nm);
    int n = 0;
    while (bus.state_out != 3'(s) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_state_timeout"}, n < 50, 1);
  endtask
  task automatic rd(int t, int exp, string nm);
    bus.rd_en = 1'b1;
    bus.rd_tag = TB'(t);
    @(negedge clk);
    bus.rd_en = 1'b0;
    check({nm, "_valid"}, bus.rd_valid, 1);
    check(nm, $signed(bus.rd_data), exp);
  endtask
  task automatic check_all(string nm);
    for (int t = 0; t < N; t++) rd(t, mcur[t], $sformatf("%s_i%0d", nm, t));
  endtask
  task automatic wload(int s, int d, int v);
    bus.ld_en = 1'b1;
    bus.ld_src = TB'(s);
    bus.ld_dst = TB'(d);
    bus.ld_weight = WW'(v);
    @(negedge clk);
    bus.ld_en = 1'b0;
    check("ld_ack", bus.ld_ack, 1);
    wm[s][d] = v;
  endtask
  task automatic do_swap(int sh);
    bus.decay_shift = SW'(sh);
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    wait_idle("swap");
    m_swap(sh);
  endtask
  initial begin
    int n;
    int base;
    steps[0] = '{3, 2, 1, 200, -40};
    steps[1] = '{3, 0, 1, 100, -20};
    steps[2] = '{3, 1, 0, 150, -30};
    steps[3] = '{3, 0, 3, 150, -30};
    steps[4] = '{3, 0, 0, 18, -4};
    steps[5] = '{3, 3, 7, 318, -64};
    steps[6] = '{3, 0, 0, 2, -1};
    bus.ld_en = 1'b0; bus.ld_src = '0; bus.ld_dst = '0; bus.ld_weight = '0;
    bus.clr_req = 1'b0; bus.swap_req = 1'b0; bus.decay_shift = '0;
    bus.rd_en = 1'b0; bus.rd_tag = '0;
    for (int s = 0; s < N; s++) for (int d = 0; d < N; d++) wm[s][d] = 0;
    for (int k = 0; k < N; k++) begin mcur[k] = 0; mnxt[k] = 0; end
    repeat (3) @(negedge clk);
    check("rst_state", bus.state_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_ld_ack", bus.ld_ack, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_spk_ready", bus.spk_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("clr_busy_cycles", n, 16);
    check("clr_state_idle", bus.state_out, 0);
    for (int t = 0; t < N; t++) rd(t, 0, $sformatf("clr_i%0d", t));
    @(negedge clk);
    check("rd_valid_drop", bus.rd_valid, 0);
    wload(3, 5, 100);
    wload(3, 6, -20);
    acc_cyc.delete();
    for (int i = 0; i < 7; i++) begin
      repeat (steps[i].nspk) fifo.push_back(steps[i].tag);
      do_swap(steps[i].shift);
      if (i == 0) check("spk_accept_spacing", acc_cyc[1] - acc_cyc[0], 2);
      rd(5, steps[i].exp5, $sformatf("step%0d_i5", i));
      rd(6, steps[i].exp6, $sformatf("step%0d_i6", i));
      check($sformatf("step%0d_sat", i), bus.sat, 0);
    end
    fifo.push_back(3);
    wait_state(1, "fetch");
    bus.ld_en = 1'b1; bus.ld_src = 4'd3; bus.ld_dst = 4'd5; bus.ld_weight = 8'd0;
    @(negedge clk);
    bus.ld_en = 1'b0;
    check("fetch_ld_ack", bus.ld_ack, 0);
    check("fetch_to_accum", bus.state_out, 3);
    do_swap(0);
    rd(5, 102, "fetch_ld_i5");
    rd(6, -21, "fetch_ld_i6");
    base = swaps;
    repeat (3) fifo.push_back(3);
    @(negedge clk);
    bus.decay_shift = '0;
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    repeat (2) @(negedge clk);
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    wait_idle("queued");
    m_swap(0);
    check("queued_swap_count", swaps - base, 1);
    rd(5, 402, "queued_i5");
    rd(6, -81, "queued_i6");
    wload(0, 1, 127);
    wload(0, 2, -128);
    repeat (1100) fifo.push_back(0);
    wait_idle("sat");
    check("sat_set", bus.sat, 1);
    do_swap(0);
    check("sat_cleared", bus.sat, 0);
    rd(1, 65535, "sat_pos_i1");
    rd(2, -65536, "sat_neg_i2");
    check_all("sat");
    for (int r = 0; r < 6; r++) begin
      repeat (12) wload($urandom_range(0, N - 1), $urandom_range(0, N - 1), int'($urandom_range(0, 255)) - 128);
      repeat ($urandom_range(0, 8)) fifo.push_back($urandom_range(0, N - 1));
      wait_idle("rnd");
      check($sformatf("rnd%0d_sat", r), bus.sat, msat);
      do_swap($urandom_range(0, 7));
      check_all($sformatf("rnd%0d", r));
    end
    repeat (4) fifo.push_back(3);
    wait_state(3, "accum");
    #2 reset = 1'b0;
    #1;
    check("arst_rd_data", bus.rd_data, 0);
    check("arst_rd_valid", bus.rd_valid, 0);
    check("arst_sat", bus.sat, 0);
    check("arst_spk_ready", bus.spk_ready, 0);
    check("arst_state", bus.state_out, 0);
    check("arst_busy", bus.busy, 0);
    fifo.delete();
    for (int k = 0; k < N; k++) begin mcur[k] = 0; mnxt[k] = 0; end
    msat = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("arst_release_state", bus.state_out, 0);
    check_all("arst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
